// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI4-Lite read arbiter:
// FSM state encoding, AXI response codes and default bus widths.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master
// that was not served last wins.
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter2.sv
// Shares one AXI4-Lite read slave between two masters, one transaction at a
// time, with round-robin arbitration taken in IDLE.
module axi_rd_arbiter2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              grant,
  output logic              busy
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_grant;
  logic       r_last_served;
  logic       w_winner;
  logic [1:0] w_req;
  logic       w_r_done;

  assign w_req    = {m1_arvalid, m0_arvalid};
  assign w_r_done = (r_state == ST_DATA) && s_rvalid && s_rready;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);

  rr_arbiter2 u_rr (
    .req         (w_req),
    .last_served (r_last_served),
    .winner      (w_winner)
  );

  // last_served resets to 1 so the first tie after reset goes to m0
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= 1'b0;
      r_last_served <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && |w_req)
        r_grant <= w_winner;
      if (w_r_done)
        r_last_served <= r_grant;
    end
  end

  always_comb begin
    w_next_state = r_state;
    s_araddr     = '0;
    s_arvalid    = 1'b0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    m0_rresp     = RESP_OKAY;
    m1_rresp     = RESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        if (|w_req)
          w_next_state = ST_ADDR;
      end
      ST_ADDR: begin
        s_arvalid = 1'b1;
        s_araddr  = r_grant ? m1_araddr : m0_araddr;
        if (r_grant) m1_arready = s_arready;
        else         m0_arready = s_arready;
        if (s_arready)
          w_next_state = ST_DATA;
      end
      ST_DATA: begin
        // Responses, including SLVERR/DECERR, pass straight through; no retry
        s_rready = r_grant ? m1_rready : m0_rready;
        if (r_grant) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && s_rready)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// Scoreboard bench for axi_rd_arbiter2: directed reads from two masters
// against a configurable slave model, with queue-based response checking.
module tb_axi_rd_arbiter2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        m0_rvalid, m0_rready, m1_rvalid, m1_rready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        grant, busy;

  axi_rd_arbiter2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {logic [31:0] data; logic [1:0] resp;} rexp_t;
  typedef struct {logic g; logic [31:0] addr;} aexp_t;
  rexp_t exp_q0[$];
  rexp_t exp_q1[$];
  aexp_t ar_q[$];
  int    ar_cyc[$];
  rexp_t e0, e1;
  aexp_t ea;
  int    rv0_cyc = -1;
  int    rv1_cyc = -1;

  // slave model configuration
  int       ar_wait  = 0;
  int       r_delay  = 0;
  logic [1:0] slv_resp = 2'd0;
  bit       slv_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, expected completion", name);
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h1000) ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
  endfunction

  // slave: accepts AR after ar_wait stalled cycles, answers r_delay cycles later
  initial begin
    int cnt;
    int guard;
    logic [31:0] a;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'd0;
    forever begin
      cnt = 0;
      s_arready = (ar_wait == 0);
      while (1) begin
        @(negedge clk);
        if (s_arvalid && s_arready) break;
        if (!s_arvalid) s_arready = (ar_wait == 0);
        else begin
          cnt++;
          if (cnt >= ar_wait) begin
            @(posedge clk); #1;
            s_arready = 1'b1;
          end
        end
      end
      a = s_araddr;
      @(posedge clk); #1;
      s_arready = 1'b0;
      repeat (r_delay) begin @(posedge clk); #1; end
      s_rvalid = 1'b1; s_rdata = slv_data(a); s_rresp = slv_resp;
      guard = 0;
      do begin @(negedge clk); guard++; end
      while (!s_rready && !slv_abort && guard < 500);
      if (guard >= 500) fail_now("slave_r_timeout");
      @(posedge clk); #1;
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'd0; slv_abort = 1'b0;
    end
  end

  // monitor: quiet-output invariants plus scoreboard pops on every handshake
  always @(negedge clk) begin
    if (!busy)
      check("idle_quiet", 64'({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}), 64'd0);
    else if (!grant)
      check("m1_nongrant_quiet", 64'({m1_arready, m1_rvalid, m1_rdata, m1_rresp}), 64'd0);
    else
      check("m0_nongrant_quiet", 64'({m0_arready, m0_rvalid, m0_rdata, m0_rresp}), 64'd0);
    if (s_arvalid && s_arready) begin
      ar_cyc.push_back(cyc);
      if (ar_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ar_unexpected: got grant %0d addr 0x%0h, expected no request", grant, s_araddr);
      end else begin
        ea = ar_q.pop_front();
        check("ar_grant", 64'(grant), 64'(ea.g));
        check("ar_addr", 64'(s_araddr), 64'(ea.addr));
      end
    end
    if (m0_rvalid && m0_rready) begin
      rv0_cyc = cyc;
      if (exp_q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m0_r_unexpected: got data 0x%0h, expected no response", m0_rdata);
      end else begin
        e0 = exp_q0.pop_front();
        check("m0_rdata", 64'(m0_rdata), 64'(e0.data));
        check("m0_rresp", 64'(m0_rresp), 64'(e0.resp));
      end
    end
    if (m1_rvalid && m1_rready) begin
      rv1_cyc = cyc;
      if (exp_q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m1_r_unexpected: got data 0x%0h, expected no response", m1_rdata);
      end else begin
        e1 = exp_q1.pop_front();
        check("m1_rdata", 64'(m1_rdata), 64'(e1.data));
        check("m1_rresp", 64'(m1_rresp), 64'(e1.resp));
      end
    end
  end

  task automatic issue(input bit m, input logic [31:0] a, output int t0);
    int g;
    @(posedge clk); #1;
    t0 = cyc;
    if (m) begin m1_araddr = a; m1_arvalid = 1'b1; end
    else   begin m0_araddr = a; m0_arvalid = 1'b1; end
    g = 0;
    do begin @(negedge clk); g++; end
    while (!(m ? m1_arready : m0_arready) && g < 100);
    if (g >= 100) fail_now(m ? "m1_arready_timeout" : "m0_arready_timeout");
    @(posedge clk); #1;
    if (m) m1_arvalid = 1'b0;
    else   m0_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0 || ar_q.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail_now("wait_idle_timeout");
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_rd(input bit m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    ar_q.push_back('{g: m, addr: a});
    if (m) exp_q1.push_back('{data: d, resp: r});
    else   exp_q0.push_back('{data: d, resp: r});
  endtask

  initial begin
    int t0, t1;
    m0_araddr = '0; m1_araddr = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;

    // reset with a request pending: nothing may leak out
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_0ABC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, grant, s_arvalid, s_rready, m0_arready, m0_rvalid,
                                m1_arready, m1_rvalid, s_araddr}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; m0_arvalid = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 64'({busy, grant, s_arvalid, s_rready, m0_arready, m0_rvalid,
                                     m1_arready, m1_rvalid, s_araddr}), 64'd0);

    // single m0 read, zero-wait slave
    rv0_cyc = -1;
    push_rd(1'b0, 32'h1000, 32'hDEADBEEF, 2'd0);
    issue(1'b0, 32'h1000, t0);
    wait_idle();
    check("m0_rvalid_latency", 64'(rv0_cyc - t0), 64'd2);

    // tie right after reset: m0 first, one idle bubble, then m1
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    ar_cyc.delete();
    push_rd(1'b0, 32'h2000, 32'h2000 ^ 32'h5A5A5A5A, 2'd0);
    push_rd(1'b1, 32'h2100, 32'h2100 ^ 32'h5A5A5A5A, 2'd0);
    fork
      issue(1'b0, 32'h2000, t0);
      issue(1'b1, 32'h2100, t1);
    join
    wait_idle();
    check("tie_ar_count", 64'(ar_cyc.size()), 64'd2);
    if (ar_cyc.size() >= 2)
      check("tie_idle_bubble", 64'(ar_cyc[1] - ar_cyc[0]), 64'd3);

    // continuous contention: grants alternate 0,1,0,1...
    for (int i = 0; i < 4; i++) begin
      push_rd(1'b0, 32'h4000 + 32'(i * 4), (32'h4000 + 32'(i * 4)) ^ 32'h5A5A5A5A, 2'd0);
      push_rd(1'b1, 32'h5000 + 32'(i * 4), (32'h5000 + 32'(i * 4)) ^ 32'h5A5A5A5A, 2'd0);
    end
    fork
      begin
        int tt;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h4000 + 32'(i * 4), tt);
      end
      begin
        int tt;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'h5000 + 32'(i * 4), tt);
      end
    join
    wait_idle();

    // stalled slave and stalled m1 rready: state holds, delivered once
    ar_wait = 4; r_delay = 5; m1_rready = 1'b0;
    settle();
    ar_cyc.delete();
    rv1_cyc = -1;
    push_rd(1'b1, 32'h6000, 32'h6000 ^ 32'h5A5A5A5A, 2'd0);
    fork
      issue(1'b1, 32'h6000, t0);
      begin
        int g;
        g = 0;
        do begin @(negedge clk); g++; end while (!m1_rvalid && g < 100);
        if (g >= 100) fail_now("m1_rvalid_timeout");
        @(posedge clk); #1;
        @(negedge clk);
        check("m1_rvalid_held", 64'({m1_rvalid, busy, grant}), 64'b111);
        @(posedge clk); #1;
        m1_rready = 1'b1;
      end
    join
    wait_idle();
    if (ar_cyc.size() >= 1)
      check("ar_stall_cycles", 64'(ar_cyc[0] - t0), 64'd5);
    check("r_stall_cycles", 64'(rv1_cyc - t0), 64'd13);
    ar_wait = 0; r_delay = 0;
    settle();

    // SLVERR forwarded unchanged to m1
    slv_resp = 2'd2;
    settle();
    push_rd(1'b1, 32'h7000, 32'h7000 ^ 32'h5A5A5A5A, 2'd2);
    issue(1'b1, 32'h7000, t0);
    wait_idle();
    check("slverr_back_idle", 64'(busy), 64'd0);
    slv_resp = 2'd0;

    // reset in DATA while the slave is presenting rvalid
    m0_rready = 1'b0;
    settle();
    ar_q.push_back('{g: 1'b0, addr: 32'h3000});
    issue(1'b0, 32'h3000, t0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", 64'({busy, grant, m0_rvalid, m1_rvalid, s_rready, s_arvalid,
                                    m0_arready, m1_arready, m0_rdata, m0_rresp}), 64'd0);
    @(negedge clk);
    check("mid_reset_next", 64'({busy, grant, m0_rvalid, m1_rvalid, s_rready, s_arvalid,
                                 m0_rdata, m0_rresp}), 64'd0);
    m0_rready = 1'b1;
    slv_abort = 1'b1;
    repeat (3) settle();

    // normal traffic resumes after the mid-transaction reset
    push_rd(1'b1, 32'h8000, 32'h8000 ^ 32'h5A5A5A5A, 2'd0);
    issue(1'b1, 32'h8000, t0);
    wait_idle();

    check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
    check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
    check("ar_q_drained", 64'(ar_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
